// File: rtl/rr_mux_arb_2ch.sv
// Two-channel round-robin arbiter with per-owner burst limiting feeding a registered output stage.
// Optional per-channel grant counters are enabled with `define ARB_STATS_EN.
module rr_mux_arb_2ch #(
  parameter int DW    = 1,
  parameter int BURST = 4,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in0_valid,
  input  logic [DW-1:0] in0_data,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [DW-1:0] in1_data,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          sel,
  output logic          busy
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] BURST_L = BURST[7:0];

  if (BURST < 1 || BURST > 255) begin : g_bad_burst
    $error("BURST must be in 1..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_t        state_reg, state_next;
  logic [7:0]    burst_cnt_reg, burst_cnt_next;
  logic          last_served_reg, last_served_next;
  logic          out_valid_reg, out_valid_next;
  logic [DW-1:0] out_data_reg, out_data_next;
  logic          sel_reg, sel_next;

  logic          load_en;
  logic          any_valid;
  logic          gnt;
  logic          accept;
  state_t        gnt_state;
  logic [1:0]    in_valid;
  logic [DW-1:0] in_data [2];
  logic [1:0]    in_ready_int;

  assign in_valid   = {in1_valid, in0_valid};
  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;

  assign load_en   = !out_valid_reg || out_ready;
  assign any_valid = |in_valid;
  assign accept    = load_en && any_valid;
  assign gnt_state = gnt ? OWN1 : OWN0;

  // A lone requester always wins; under contention the owner keeps the
  // grant until it has used up its burst, then the other side gets a turn.
  always_comb begin
    gnt = !last_served_reg;
    if (in_valid == 2'b01) begin
      gnt = 1'b0;
    end else if (in_valid == 2'b10) begin
      gnt = 1'b1;
    end else if (state_reg == OWN0 && burst_cnt_reg < BURST_L) begin
      gnt = 1'b0;
    end else if (state_reg == OWN1 && burst_cnt_reg < BURST_L) begin
      gnt = 1'b1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign in_ready_int[gi] = accept && in_valid[gi] && (gnt == gi[0]);
  end

  // Flops are held in reset while rst_n is low, so no handshake may be
  // advertised upstream during that time.
  assign in0_ready = rst_n && in_ready_int[0];
  assign in1_ready = rst_n && in_ready_int[1];

  always_comb begin
    state_next       = state_reg;
    burst_cnt_next   = burst_cnt_reg;
    last_served_next = last_served_reg;
    out_valid_next   = out_valid_reg;
    out_data_next    = out_data_reg;
    sel_next         = sel_reg;
    if (load_en) begin
      if (any_valid) begin
        out_valid_next   = 1'b1;
        out_data_next    = in_data[gnt];
        sel_next         = gnt;
        last_served_next = gnt;
        if (state_reg == gnt_state) begin
          if (burst_cnt_reg < BURST_L) begin
            burst_cnt_next = burst_cnt_reg + 8'd1;
          end
        end else begin
          state_next     = gnt_state;
          burst_cnt_next = 8'd1;
        end
      end else begin
        out_valid_next = 1'b0;
        state_next     = IDLE;
        burst_cnt_next = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      burst_cnt_reg   <= 8'd0;
      last_served_reg <= 1'b1;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      sel_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      burst_cnt_reg   <= burst_cnt_next;
      last_served_reg <= last_served_next;
      out_valid_reg   <= out_valid_next;
      out_data_reg    <= out_data_next;
      sel_reg         <= sel_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign sel       = sel_reg;
  assign busy      = (state_reg != IDLE);

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] gnt_cnt_reg [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_stats
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gnt_cnt_reg[gi] <= '0;
      end else if (in_ready_int[gi] && !(&gnt_cnt_reg[gi])) begin
        gnt_cnt_reg[gi] <= gnt_cnt_reg[gi] + 1'b1;
      end
    end
  end

  assign gnt_cnt0 = gnt_cnt_reg[0];
  assign gnt_cnt1 = gnt_cnt_reg[1];
`endif

endmodule

// File: tb/tb_rr_mux_arb_2ch.sv
// Bench for rr_mux_arb_2ch: a vector table for arbitration order plus a scoreboard for beat integrity.
module tb_rr_mux_arb_2ch;

  localparam int DW    = 1;
  localparam int BURST = 4;
  localparam int CNT_W = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in0_valid, in1_valid, in0_ready, in1_ready;
  logic [DW-1:0] in0_data, in1_data, out_data;
  logic          out_valid, out_ready, sel, busy;
`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_mux_arb_2ch #(.DW(DW), .BURST(BURST), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
`ifdef ARB_STATS_EN
    ,
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic v1, input logic d0, input logic d1, input logic ordy);
    in0_valid = v0;
    in1_valid = v1;
    in0_data  = d0;
    in1_data  = d1;
    out_ready = ordy;
  endtask

  // Scoreboard: each accepted beat is queued with its source channel and
  // must reappear, in order, when the output handshake completes.
  typedef struct packed {
    logic [DW-1:0] data;
    logic          ch;
  } beat_t;

  beat_t sb_q[$];
  beat_t sb_head;

  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_onehot", {31'd0, in0_ready & in1_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_beat", 32'd1, 32'd0);
        end else begin
          sb_head = sb_q.pop_front();
          check("sb_data", {31'd0, out_data}, {31'd0, sb_head.data});
          check("sb_sel", {31'd0, sel}, {31'd0, sb_head.ch});
          $display("beat out: data=%0d sel=%0d", out_data, sel);
        end
      end
      if (in0_valid && in0_ready) sb_q.push_back({in0_data, 1'b0});
      if (in1_valid && in1_ready) sb_q.push_back({in1_data, 1'b1});
    end
  end

  always @(negedge rst_n) sb_q.delete();

  typedef struct {
    logic v0, v1, d0, d1, ordy;
    logic r0, r1, ov, sel, busy;
  } vec_t;

  vec_t vt[21];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        v0    v1    d0    d1    ordy  r0    r1    ov    sel   busy
    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[20] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset held with random inputs: outputs quiet, no readys.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      check("rst_in0_ready", {31'd0, in0_ready}, 32'd0);
      check("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sel", {31'd0, sel}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      $display("reset cycle %0d: v0=%0d v1=%0d", i, in0_valid, in1_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention, backpressure, valid drop and idle return from the table.
    for (int i = 0; i < 21; i++) begin
      drive(vt[i].v0, vt[i].v1, vt[i].d0, vt[i].d1, vt[i].ordy);
      @(negedge clk);
      check($sformatf("vec%0d_in0_ready", i), {31'd0, in0_ready}, {31'd0, vt[i].r0});
      check($sformatf("vec%0d_in1_ready", i), {31'd0, in1_ready}, {31'd0, vt[i].r1});
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vt[i].ov});
      check($sformatf("vec%0d_sel", i), {31'd0, sel}, {31'd0, vt[i].sel});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].busy});
      $display("vec %0d: v0=%0d v1=%0d ordy=%0d -> r0=%0d r1=%0d ov=%0d sel=%0d busy=%0d",
               i, vt[i].v0, vt[i].v1, vt[i].ordy, in0_ready, in1_ready, out_valid, sel, busy);
    end

    // Single stream on channel 0: data 1,0,1 one cycle after each accept.
    for (int i = 0; i < 3; i++) begin
      logic d;
      d = (i != 1);
      drive(1'b1, 1'b0, d, 1'b1, 1'b1);
      @(negedge clk);
      check("stream_in0_ready", {31'd0, in0_ready}, 32'd1);
      check("stream_in1_ready", {31'd0, in1_ready}, 32'd0);
      @(posedge clk); #1;
      check("stream_out_data", {31'd0, out_data}, {31'd0, d});
      check("stream_sel", {31'd0, sel}, 32'd0);
      $display("stream beat %0d: data=%0d sel=%0d", i, out_data, sel);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;

    // Two channel-1 beats put the arbiter in OWN1 with burst_cnt=2.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
    end
    check("pre_reset_sel", {31'd0, sel}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_sel", {31'd0, sel}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_in0_ready", {31'd0, in0_ready}, 32'd0);
    check("async_in1_ready", {31'd0, in1_ready}, 32'd0);
    $display("async reset: ov=%0d sel=%0d busy=%0d", out_valid, sel, busy);
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in0_ready", {31'd0, in0_ready}, 32'd1);
    check("post_rst_in1_ready", {31'd0, in1_ready}, 32'd0);
    @(posedge clk); #1;
    check("post_rst_sel", {31'd0, sel}, 32'd0);
    check("post_rst_out_data", {31'd0, out_data}, 32'd1);
    $display("post reset accept: sel=%0d data=%0d", sel, out_data);

    // Drain and confirm every accepted beat came out exactly once.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("sb_empty", sb_q.size(), 32'd0);
    check("drained_out_valid", {31'd0, out_valid}, 32'd0);

`ifdef ARB_STATS_EN
    rst_n = 1'b0;
    #1;
    check("stats_rst_cnt0", {29'd0, gnt_cnt0}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'(i), 1'b0, 1'b1);
      @(posedge clk); #1;
      if (i == 2) check("stats_cnt0_3", {29'd0, gnt_cnt0}, 32'd3);
      $display("stats beat %0d: gnt_cnt0=%0d gnt_cnt1=%0d", i, gnt_cnt0, gnt_cnt1);
    end
    check("stats_cnt0_sat", {29'd0, gnt_cnt0}, 32'd7);
    check("stats_cnt1_zero", {29'd0, gnt_cnt1}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
